rw_register: RTL and testbench

- Single-word read/write storage register with optional per-byte write lanes.
- Used as a control/status word behind bus-interface logic, such as a Wishbone HyperRAM controller config register.
- Samples `data_in` on a write strobe and continuously drives the stored value.
- Holds its value whenever no write is requested.

---
 rtl/rw_register_pkg.sv | 12 +
 rtl/rw_register_if.sv | 30 +++
 rtl/rw_byte_lane.sv | 22 ++
 rtl/rw_register.sv | 80 ++++++++
 tb/tb_rw_register.sv | 125 ++++++++++++
 5 files changed

// File: rtl/rw_register_pkg.sv
// Shared constants and types for the rw_register control/status word.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rw_register_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] RESET_VALUE = '0;
    localparam int NUM_LANES = DATA_WIDTH / 8;

    typedef logic [DATA_WIDTH-1:0] data_word_t;

endpackage

// File: rtl/rw_register_if.sv
// Bus-side signal bundle for rw_register: write request in, stored word and ack out.
// Latency: n/a (wiring only).
// Backpressure: none; every write is accepted in the cycle it is presented.
interface rw_register_if #(
    parameter int WIDTH = 32
);

    logic [WIDTH-1:0]   data_in;
    logic               wren;
    logic [WIDTH/8-1:0] byte_sel;
    logic [WIDTH-1:0]   data_out;
    logic               wr_ack;

    modport master (
        output data_in,
        output wren,
        output byte_sel,
        input  data_out,
        input  wr_ack
    );

    modport slave (
        input  data_in,
        input  wren,
        input  byte_sel,
        output data_out,
        output wr_ack
    );

endinterface

// File: rtl/rw_byte_lane.sv
// One 8-bit lane of the storage word with its own reset value and write enable.
// Latency: 1 cycle from enabled edge to q.
// Backpressure: none; holds q whenever en is low.
module rw_byte_lane #(
    parameter logic [7:0] RESET_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] d,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_BYTE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rw_register.sv
// Read/write storage word with per-byte write lanes and a one-cycle write ack; RW_REGISTER_FORMAL_EN adds properties.
// Latency: 1 cycle from write edge to data_out and wr_ack.
// Backpressure: none; every wren cycle is accepted, data_out is always valid.
module rw_register
    import rw_register_pkg::*;
#(
    parameter int               WIDTH       = DATA_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = rw_register_pkg::RESET_VALUE
) (
    input logic          clk,
    input logic          rst,
    rw_register_if.slave bus
);

    localparam int LANES = WIDTH / 8;

    logic [WIDTH-1:0] data_q;
    logic             wr_ack_q;

    // Each lane only updates when the write hits it, so unselected lanes hold.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        rw_byte_lane #(
            .RESET_BYTE (RESET_VALUE[8*i +: 8])
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (bus.wren & bus.byte_sel[i]),
            .d   (bus.data_in[8*i +: 8]),
            .q   (data_q[8*i +: 8])
        );
    end

    // Ack follows wren even with an empty lane mask.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ack_q <= 1'b0;
        end else begin
            wr_ack_q <= bus.wren;
        end
    end

    assign bus.data_out = data_q;
    assign bus.wr_ack   = wr_ack_q;

`ifdef RW_REGISTER_FORMAL_EN
    logic past_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            past_valid <= 1'b0;
        end else begin
            past_valid <= 1'b1;
        end
    end

    always_comb begin
        if (!rst) begin
            a_reset_value : assert (bus.data_out == RESET_VALUE);
        end
    end

    a_release_idle : assert property (@(posedge clk) disable iff (!rst)
        (!past_valid && !bus.wren) |=> (bus.data_out == RESET_VALUE));

    a_full_write : assert property (@(posedge clk) disable iff (!rst)
        (bus.wren && (&bus.byte_sel)) |=> (bus.data_out == $past(bus.data_in)));

    a_hold : assert property (@(posedge clk) disable iff (!rst)
        (!bus.wren) |=> $stable(bus.data_out));

    a_ack : assert property (@(posedge clk) disable iff (!rst)
        past_valid |-> (bus.wr_ack == $past(bus.wren)));

    c_msb_then_zero : cover property (@(posedge clk) disable iff (!rst)
        (bus.wren && (bus.data_in == {1'b1, {(WIDTH-1){1'b0}}}))
        ##1 (bus.wren && (bus.data_in == '0))
        ##1 (!bus.wren) [*2]);
`endif

endmodule

// File: tb/tb_rw_register.sv
// Directed bench for rw_register: reset, full/partial writes, hold, ack, async reset.
// Inputs change #1 after posedge; outputs checked #1 after the edge that produced them.
module tb_rw_register;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rw_register_if #(.WIDTH(32)) bus ();

    rw_register #(
        .WIDTH       (32),
        .RESET_VALUE (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] sel, input logic [31:0] d);
        bus.wren     = we;
        bus.byte_sel = sel;
        bus.data_in  = d;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        drive(1'b1, 4'hF, 32'hFFFF_FFFF);
        #1;
        check("reset_data_t0", bus.data_out, 32'h0000_0000);
        check("reset_ack_t0", {31'b0, bus.wr_ack}, 32'h0);

        // Writes during reset must be ignored
        edge_step();
        edge_step();
        check("reset_data_held", bus.data_out, 32'h0000_0000);
        check("reset_ack_held", {31'b0, bus.wr_ack}, 32'h0);

        // First edge after release accepts the write
        rst = 1'b1;
        drive(1'b1, 4'hF, 32'h8000_0000);
        edge_step();
        check("release_write_data", bus.data_out, 32'h8000_0000);
        check("release_write_ack", {31'b0, bus.wr_ack}, 32'h1);

        drive(1'b1, 4'hF, 32'h0000_0000);
        edge_step();
        check("b2b_write_data", bus.data_out, 32'h0000_0000);
        check("b2b_write_ack", {31'b0, bus.wr_ack}, 32'h1);

        drive(1'b0, 4'hF, 32'h1234_5678);
        edge_step();
        check("hold1_data", bus.data_out, 32'h0000_0000);
        check("hold1_ack", {31'b0, bus.wr_ack}, 32'h0);
        drive(1'b0, 4'hF, 32'hEDCB_A987);
        edge_step();
        check("hold2_data", bus.data_out, 32'h0000_0000);
        check("hold2_ack", {31'b0, bus.wr_ack}, 32'h0);

        // Empty lane mask: ack pulses, data unchanged
        drive(1'b1, 4'h0, 32'hFFFF_FFFF);
        edge_step();
        check("nomask_data", bus.data_out, 32'h0000_0000);
        check("nomask_ack", {31'b0, bus.wr_ack}, 32'h1);

        drive(1'b1, 4'hF, 32'hAABB_CCDD);
        edge_step();
        check("full_write", bus.data_out, 32'hAABB_CCDD);
        drive(1'b1, 4'h5, 32'h1122_3344);
        edge_step();
        check("lanes_0_2", bus.data_out, 32'hAA22_CC44);
        drive(1'b1, 4'hA, 32'h5566_7788);
        edge_step();
        check("lanes_1_3", bus.data_out, 32'h5522_7744);
        drive(1'b1, 4'h8, 32'h0100_0000);
        edge_step();
        check("lane_3_only", bus.data_out, 32'h0122_7744);
        drive(1'b0, 4'hF, 32'h0);
        edge_step();
        check("ack_drop", {31'b0, bus.wr_ack}, 32'h0);

        drive(1'b1, 4'hF, 32'hDEAD_BEEF);
        edge_step();
        check("pre_reset_data", bus.data_out, 32'hDEAD_BEEF);

        // Async reset mid-cycle with a write pending
        drive(1'b1, 4'hF, 32'h1234_5678);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_data", bus.data_out, 32'h0000_0000);
        check("async_reset_ack", {31'b0, bus.wr_ack}, 32'h0);
        edge_step();
        check("async_reset_hold", bus.data_out, 32'h0000_0000);

        rst = 1'b1;
        drive(1'b1, 4'hF, 32'hCAFE_F00D);
        edge_step();
        check("post_reset_write", bus.data_out, 32'hCAFE_F00D);
        check("post_reset_ack", {31'b0, bus.wr_ack}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
